// File: rtl/lsu_dtag_wrctl_pkg.sv
// Shared definitions for the D-cache tag write controller.
//   - Array geometry: tag width (excluding parity), set index width, way count.
//   - way_onehot(): binary way number to one-hot way mask.
package lsu_dtag_wrctl_pkg;

    localparam int L1D_TAG_W     = 29;             // tag bits per way, PA[39:11]
    localparam int L1D_PAR_W     = 1;              // one even-parity bit per way
    localparam int L1D_DATA_W    = L1D_TAG_W + L1D_PAR_W;
    localparam int L1D_IDX_W     = 7;              // 128 sets
    localparam int L1D_WAY_COUNT = 4;
    localparam int L1D_WAY_BIN_W = 2;

    function automatic logic [L1D_WAY_COUNT-1:0] way_onehot(input logic [L1D_WAY_BIN_W-1:0] way);
        logic [L1D_WAY_COUNT-1:0] mask;
        mask      = '0;
        mask[way] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/lsu_dtag_wrctl_par_gen.sv
// Even-parity generator for a dtag entry (combinational).
// The tag is reduced in four byte-sized groups ([7:0], [15:8], [23:16], [28:24])
// so the write side has the same XOR tree shape as the read-side checker.
// Ports:
//   tag    in   L1D_TAG_W  tag being written
//   flip   in   1          invert the generated parity (error injection)
//   parity out  1          stored parity bit; ^{tag, parity} == 0 when flip is 0
module lsu_dtag_wrctl_par_gen
    import lsu_dtag_wrctl_pkg::*;
(
    input  logic [L1D_TAG_W-1:0] tag,
    input  logic                 flip,
    output logic                 parity
);

    logic [3:0] grp_par;

    assign grp_par[0] = ^tag[7:0];
    assign grp_par[1] = ^tag[15:8];
    assign grp_par[2] = ^tag[23:16];
    assign grp_par[3] = ^tag[28:24];

    assign parity = (^grp_par) ^ flip;

endmodule

// File: rtl/lsu_dtag_wrctl.sv
// D-cache tag array write controller.
// Arbitrates L2 fill tag writes and ASI diagnostic tag writes, and runs a
// full-array invalidate sweep after every reset and on sweep_req. All writes
// leave through one registered port: a request granted in cycle N is acked
// combinationally in N and written to dtag in N+1.
// Handshake: a requester holds *_req with stable payload until it sees *_ack
// high in the same cycle; a req still high in the next cycle is a new request.
// Ports:
//   rclk, rst_l, se                     clock, async active-low reset, scan enable
//   fill_req/idx/way/tag, fill_ack      L2 fill tag write request
//   diag_req/idx/way/tag/par_flip,
//   diag_ack                            ASI diagnostic tag write request
//   sweep_req, sweep_busy               invalidate sweep start pulse / in progress
//   dtag_wr_en/idx/way/data             registered tag array write port
module lsu_dtag_wrctl
    import lsu_dtag_wrctl_pkg::*;
(
    input  logic                     rclk,
    input  logic                     rst_l,
    input  logic                     se,
    input  logic                     fill_req,
    input  logic [L1D_IDX_W-1:0]     fill_idx,
    input  logic [L1D_WAY_BIN_W-1:0] fill_way,
    input  logic [L1D_TAG_W-1:0]     fill_tag,
    output logic                     fill_ack,
    input  logic                     diag_req,
    input  logic [L1D_IDX_W-1:0]     diag_idx,
    input  logic [L1D_WAY_BIN_W-1:0] diag_way,
    input  logic [L1D_TAG_W-1:0]     diag_tag,
    input  logic                     diag_par_flip,
    output logic                     diag_ack,
    input  logic                     sweep_req,
    output logic                     sweep_busy,
    output logic                     dtag_wr_en,
    output logic [L1D_IDX_W-1:0]     dtag_wr_idx,
    output logic [L1D_WAY_COUNT-1:0] dtag_wr_way,
    output logic [L1D_DATA_W-1:0]    dtag_wr_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int OUT_W = 1 + L1D_IDX_W + L1D_WAY_COUNT + L1D_DATA_W;
    localparam logic [L1D_IDX_W-1:0] LAST_IDX = '1;

    // Scan is handled by the flop library in the full chip; unused here.
    logic unused_se;
    assign unused_se = se;

    state_t               state_q, state_d;
    logic [L1D_IDX_W-1:0] cnt_q, cnt_d;
    // Set when the last grant went to fill while diag was also waiting;
    // gives diag the next contested slot so the two alternate.
    logic                 fill_last_q, fill_last_d;
    logic                 fill_gnt, diag_gnt, sweep_wr;

    // ---------------- FSM and arbitration ----------------
    always_ff @(posedge rclk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= ST_SWEEP;   // array is always initialised after reset
            cnt_q       <= '0;
            fill_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fill_last_q <= fill_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fill_last_d = fill_last_q;
        fill_gnt    = 1'b0;
        diag_gnt    = 1'b0;
        sweep_wr    = 1'b0;
        case (state_q)
            ST_SWEEP: begin
                sweep_wr = 1'b1;
                cnt_d    = cnt_q + 1'b1;   // wraps 127 -> 0
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                // The sweep's first write lands one cycle after any grant
                // made here, so a grant and sweep start may share this cycle.
                if (sweep_req) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                end
                if (fill_req && !(diag_req && fill_last_q)) begin
                    fill_gnt    = 1'b1;
                    fill_last_d = diag_req;
                end else if (diag_req) begin
                    diag_gnt    = 1'b1;
                    fill_last_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign fill_ack   = fill_gnt;
    assign diag_ack   = diag_gnt;
    assign sweep_busy = (state_q == ST_SWEEP);

    // ---------------- write data path ----------------
    logic [L1D_TAG_W-1:0]     tag_sel;
    logic [L1D_IDX_W-1:0]     idx_sel;
    logic [L1D_WAY_BIN_W-1:0] way_sel;
    logic                     par_bit;

    assign tag_sel = diag_gnt ? diag_tag : fill_tag;
    assign idx_sel = diag_gnt ? diag_idx : fill_idx;
    assign way_sel = diag_gnt ? diag_way : fill_way;

    lsu_dtag_wrctl_par_gen u_par_gen (
        .tag    (tag_sel),
        .flip   (diag_gnt & diag_par_flip),
        .parity (par_bit)
    );

    // Single output flop bank {wr_en, idx, way, data}. Without a write the
    // enable drops and idx/way/data keep their last value.
    logic [OUT_W-1:0] out_q, out_d;

    always_comb begin
        out_d = {1'b0, out_q[OUT_W-2:0]};
        if (sweep_wr) begin
            out_d = {1'b1, cnt_q, {L1D_WAY_COUNT{1'b1}}, {L1D_DATA_W{1'b0}}};
        end else if (fill_gnt || diag_gnt) begin
            out_d = {1'b1, idx_sel, way_onehot(way_sel), par_bit, tag_sel};
        end
    end

    always_ff @(posedge rclk or negedge rst_l) begin
        if (!rst_l) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign {dtag_wr_en, dtag_wr_idx, dtag_wr_way, dtag_wr_data} = out_q;

endmodule
